// File: rtl/fp_pkg.sv
// Shared definitions for the Altair front-panel switch row: switch codes, switch kinds, FSM states.
// Used by the switch driver, its momentary timer and the front-panel mapping block.
// Pure definitions, no logic, no latency, no flow control.
package fp_pkg;

  localparam int         NUM_SWITCHES = 25;
  localparam logic [4:0] LAST_IDX     = 5'd24;

  // Two-position codes
  localparam logic [1:0] SW2_DOWN = 2'd0;
  localparam logic [1:0] SW2_UP   = 2'd1;
  // Three-position codes; code 3 is never driven
  localparam logic [1:0] SW3_MID  = 2'd0;
  localparam logic [1:0] SW3_DOWN = 2'd1;
  localparam logic [1:0] SW3_UP   = 2'd2;

  typedef enum logic [1:0] {
    SW_LATCH2,
    SW_MOM2,
    SW_MOM3
  } sw_kind_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } fsm_t;

  // Index 18 is STEP (momentary up only), 19-22 are three-position momentaries,
  // everything else latches.
  function automatic sw_kind_t sw_kind(input logic [4:0] idx);
    if (idx == 5'd18) return SW_MOM2;
    if (idx >= 5'd19 && idx <= 5'd22) return SW_MOM3;
    return SW_LATCH2;
  endfunction

endpackage

// File: rtl/front_panel_switch_driver_if.sv
// Button inputs and switch-row outputs of the front-panel switch driver.
// master = the driver (consumes buttons, drives codes/cursor/busy); slave = the user/panel side.
// Level signals only; no handshake, the driver never stalls its inputs.
interface front_panel_switch_driver_if;
  import fp_pkg::*;

  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic [1:0] switches_status [0:NUM_SWITCHES-1];
  logic [4:0] cursor;
  logic       busy;

  modport master (
    input  btn_left, btn_right, btn_up, btn_down,
    output switches_status, cursor, busy
  );

  modport slave (
    output btn_left, btn_right, btn_up, btn_down,
    input  switches_status, cursor, busy
  );

endinterface

// File: rtl/fp_momentary_timer.sv
// Hold timer for a thrown momentary switch: IDLE/HOLD FSM plus down-counter.
// Latency: busy rises the edge after start; done pulses in the last of hold_len busy cycles.
// No backpressure: start is ignored while busy.
// Ports: clk, reset (sync, active-high), start, hold_len (>=1), busy, done.
module fp_momentary_timer
  import fp_pkg::*;
#(
  parameter int unsigned W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] hold_len,
  output logic         busy,
  output logic         done
);

  fsm_t         state;
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_HOLD;
            cnt   <= hold_len - W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_HOLD);
  // Asserted during the final held cycle so the owner clears the switch on the same edge
  // the FSM drops back to IDLE.
  assign done = busy && (cnt == '0);

endmodule

// File: rtl/front_panel_switch_driver.sv
// Cursor/throw controller producing the 25 Altair front-panel switch codes from nav buttons.
// Latency: 1 cycle from the edge that first samples a button high to the visible change.
// No backpressure: throws arriving while a momentary switch is held are dropped.
// Ports: clk, reset (sync, active-high), sw_if (buttons in; switches_status, cursor, busy out).
// Optional: define FP_SWITCH_AUTOREPEAT_EN for left/right auto-repeat.
module front_panel_switch_driver
  import fp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 2500000,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic                        clk,
  input  logic                        reset,
  front_panel_switch_driver_if.master sw_if
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic       btn_left_q, btn_right_q, btn_up_q, btn_down_q;
  logic       ev_left, ev_right, ev_up, ev_down;
  logic       mv_left, mv_right;
  logic       act_up, act_down, start;
  logic       busy, hold_done;
  logic [4:0] cursor_q;
  logic [4:0] held_idx;
  logic [1:0] status_q [0:NUM_SWITCHES-1];
  sw_kind_t   kind;

  assign ev_left  = sw_if.btn_left  & ~btn_left_q;
  assign ev_right = sw_if.btn_right & ~btn_right_q;
  assign ev_up    = sw_if.btn_up    & ~btn_up_q;
  assign ev_down  = sw_if.btn_down  & ~btn_down_q;

`ifdef FP_SWITCH_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(((REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES) + 1);

  logic             only_left, only_right, rpt_active, rpt_fire;
  logic [RPT_W-1:0] rpt_cnt;

  assign only_left  = sw_if.btn_left  & ~sw_if.btn_right;
  assign only_right = sw_if.btn_right & ~sw_if.btn_left;
  // A fresh edge reloads the delay instead of firing; the held direction is always the
  // single button still high, since a both-high overlap clears the repeat state.
  assign rpt_fire = rpt_active & (only_left | only_right) & ~(ev_left | ev_right) & (rpt_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || !(only_left || only_right)) begin
      rpt_active <= 1'b0;
      rpt_cnt    <= '0;
    end else if ((only_left && ev_left) || (only_right && ev_right)) begin
      rpt_active <= 1'b1;
      rpt_cnt    <= RPT_W'(REPEAT_DELAY - 1);
    end else if (rpt_active) begin
      rpt_cnt <= (rpt_cnt == '0) ? RPT_W'(REPEAT_CYCLES - 1) : rpt_cnt - RPT_W'(1);
    end
  end

  assign mv_left  = ev_left  | (rpt_fire & only_left);
  assign mv_right = ev_right | (rpt_fire & only_right);
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_CYCLES};
  assign mv_left  = ev_left;
  assign mv_right = ev_right;
`endif

  // Throws are dropped entirely while a momentary switch is held, and simultaneous
  // up+down cancel each other.
  assign kind     = sw_kind(cursor_q);
  assign act_up   = ev_up   & ~ev_down & ~busy;
  assign act_down = ev_down & ~ev_up   & ~busy;
  assign start    = ((kind == SW_MOM2) & act_up) | ((kind == SW_MOM3) & (act_up | act_down));

  fp_momentary_timer #(
    .W (HOLD_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .hold_len (HOLD_W'(HOLD_CYCLES)),
    .busy     (busy),
    .done     (hold_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_left_q  <= 1'b0;
      btn_right_q <= 1'b0;
      btn_up_q    <= 1'b0;
      btn_down_q  <= 1'b0;
      cursor_q    <= 5'd0;
      held_idx    <= 5'd0;
      for (int i = 0; i < NUM_SWITCHES; i++) status_q[i] <= SW2_DOWN;
    end else begin
      btn_left_q  <= sw_if.btn_left;
      btn_right_q <= sw_if.btn_right;
      btn_up_q    <= sw_if.btn_up;
      btn_down_q  <= sw_if.btn_down;

      // Neutral is code 0 for both momentary kinds, so only the index needs latching.
      if (hold_done) status_q[held_idx] <= SW3_MID;

      // Action uses the pre-move cursor; the move below lands on the same edge.
      if (act_up || act_down) begin
        unique case (kind)
          SW_LATCH2: status_q[cursor_q] <= act_up ? SW2_UP : SW2_DOWN;
          SW_MOM2: begin
            if (act_up) begin
              status_q[cursor_q] <= SW2_UP;
              held_idx           <= cursor_q;
            end
          end
          SW_MOM3: begin
            status_q[cursor_q] <= act_up ? SW3_UP : SW3_DOWN;
            held_idx           <= cursor_q;
          end
          default: ;
        endcase
      end

      if (mv_right && !mv_left)
        cursor_q <= (cursor_q == LAST_IDX) ? 5'd0 : cursor_q + 5'd1;
      else if (mv_left && !mv_right)
        cursor_q <= (cursor_q == 5'd0) ? LAST_IDX : cursor_q - 5'd1;
    end
  end

  assign sw_if.switches_status = status_q;
  assign sw_if.cursor          = cursor_q;
  assign sw_if.busy            = busy;

endmodule
